neopixel_write_sched: RTL and testbench

NEOPIXEL_WRITE_SCHED -- requirements
Module: neopixel_write_sched

---
 rtl/neopixel_write_sched.sv | 131 +++++++++++++
 tb/tb_neopixel_write_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_write_sched.sv
// Pixel write scheduler: merges single CPU pixel writes with a block fill
// engine onto the one-write-per-cycle pixel port of the neopixel driver.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no fill in progress; CPU writes always accepted
// FILL  | fill engine active; fill and CPU writes share the port round-robin
module neopixel_write_sched #(
    parameter int PIXELS = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cpu_valid,
    input  logic [7:0]  i_cpu_addr,
    input  logic [23:0] i_cpu_data,
    output logic        o_cpu_ready,
    input  logic        i_fill_start,
    input  logic [7:0]  i_fill_base,
    input  logic [8:0]  i_fill_count,
    input  logic [23:0] i_fill_color,
    output logic        o_fill_busy,
    output logic        o_fill_done,
    output logic [7:0]  o_rd_addr,
    output logic        o_rd_wen,
    output logic [23:0] o_rd_data
);

    localparam logic [7:0] LAST_ADDR = 8'(PIXELS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  fill_ptr;
    logic [8:0]  fill_left;
    logic [23:0] fill_color;
    logic        last_fill;

    logic        cpu_grant;
    logic        fill_grant;
    logic        fill_last;
    logic        start_take;
    logic [7:0]  base_wrapped;
    logic [7:0]  ptr_next;

    // Base may exceed the strip length, so fold it into range once at latch time.
    assign base_wrapped = 8'(9'(i_fill_base) % 9'(PIXELS));
    assign ptr_next     = (fill_ptr == LAST_ADDR) ? 8'd0 : fill_ptr + 8'd1;
    assign o_fill_busy  = (state == FILL);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, arbitration and CPU handshake; everything is masked during reset.
    always_comb begin
        state_next  = state;
        o_cpu_ready = 1'b0;
        cpu_grant   = 1'b0;
        fill_grant  = 1'b0;
        fill_last   = 1'b0;
        start_take  = 1'b0;
        if (!i_reset) begin
            case (state)
                IDLE: begin
                    o_cpu_ready = 1'b1;
                    start_take  = i_fill_start;
                    if (i_fill_start && (i_fill_count != 9'd0)) begin
                        state_next = FILL;
                    end
                end
                FILL: begin
                    // CPU only gets a turn right after a fill write.
                    o_cpu_ready = last_fill;
                end
                default: state_next = IDLE;
            endcase
            cpu_grant = i_cpu_valid && o_cpu_ready;
            if (state == FILL) begin
                fill_grant = !cpu_grant;
                fill_last  = fill_grant && (fill_left == 9'd1);
                if (fill_last) begin
                    state_next = IDLE;
                end
            end
        end
    end

    // Registered write port, fill bookkeeping and completion pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_wen    <= 1'b0;
            o_rd_addr   <= 8'd0;
            o_rd_data   <= 24'd0;
            o_fill_done <= 1'b0;
            last_fill   <= 1'b0;
            fill_ptr    <= 8'd0;
            fill_left   <= 9'd0;
            fill_color  <= 24'd0;
        end else begin
            o_rd_wen    <= cpu_grant || fill_grant;
            o_fill_done <= fill_last || (start_take && (i_fill_count == 9'd0));
            last_fill   <= fill_grant;
            if (cpu_grant) begin
                o_rd_addr <= i_cpu_addr;
                o_rd_data <= i_cpu_data;
            end else if (fill_grant) begin
                o_rd_addr <= fill_ptr;
                o_rd_data <= fill_color;
            end
            if (start_take) begin
                fill_ptr   <= base_wrapped;
                fill_left  <= i_fill_count;
                fill_color <= i_fill_color;
            end else if (fill_grant) begin
                fill_ptr  <= ptr_next;
                fill_left <= fill_left - 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_neopixel_write_sched.sv
// Bench for neopixel_write_sched: expected pixel writes (address, data,
// done flag, cycle) are queued as stimulus is driven and checked by a
// monitor as the DUT issues them.
module tb_neopixel_write_sched;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_cpu_valid;
    logic [7:0]  i_cpu_addr;
    logic [23:0] i_cpu_data;
    logic        o_cpu_ready;
    logic        i_fill_start;
    logic [7:0]  i_fill_base;
    logic [8:0]  i_fill_count;
    logic [23:0] i_fill_color;
    logic        o_fill_busy;
    logic        o_fill_done;
    logic [7:0]  o_rd_addr;
    logic        o_rd_wen;
    logic [23:0] o_rd_data;

    neopixel_write_sched #(.PIXELS(256)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_cpu_valid  (i_cpu_valid),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_data   (i_cpu_data),
        .o_cpu_ready  (o_cpu_ready),
        .i_fill_start (i_fill_start),
        .i_fill_base  (i_fill_base),
        .i_fill_count (i_fill_count),
        .i_fill_color (i_fill_color),
        .o_fill_busy  (o_fill_busy),
        .o_fill_done  (o_fill_done),
        .o_rd_addr    (o_rd_addr),
        .o_rd_wen     (o_rd_wen),
        .o_rd_data    (o_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] data;
        logic        done;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] data;
        logic [7:0]  exp_addr;
        logic [23:0] exp_data;
    } cpu_vec_t;

    wr_t sb[$];
    int  tests_run    = 0;
    int  tests_failed = 0;
    int  cyc          = 0;
    int  done_cnt     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [7:0] a, input logic [23:0] d, input logic dn, input int cy);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.done = dn;
        w.cyc  = cy;
        sb.push_back(w);
    endfunction

    // Monitor: every issued write must match the head of the scoreboard.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (o_rd_wen === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", {24'd0, o_rd_addr}, 32'hFFFF_FFFF);
                end else begin
                    w = sb.pop_front();
                    check("wr_addr", {24'd0, o_rd_addr}, {24'd0, w.addr});
                    check("wr_data", {8'd0, o_rd_data}, {8'd0, w.data});
                    check("wr_done", {31'd0, o_fill_done}, {31'd0, w.done});
                    check("wr_cycle", cyc, w.cyc);
                end
            end
            if (o_fill_done === 1'b1) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_fill(input logic [7:0] b, input logic [8:0] n, input logic [23:0] col);
        i_fill_start = 1'b1;
        i_fill_base  = b;
        i_fill_count = n;
        i_fill_color = col;
        @(negedge clk);
        i_fill_start = 1'b0;
    endtask

    initial begin
        cpu_vec_t vecs[5];
        int c;

        vecs[0] = '{8'h00, 24'hFF0000, 8'h00, 24'hFF0000};
        vecs[1] = '{8'h01, 24'h00FF00, 8'h01, 24'h00FF00};
        vecs[2] = '{8'h02, 24'h0000FF, 8'h02, 24'h0000FF};
        vecs[3] = '{8'hFF, 24'hABCDEF, 8'hFF, 24'hABCDEF};
        vecs[4] = '{8'h7E, 24'h000001, 8'h7E, 24'h000001};

        // Reset with requests pending: all ignored, ready held low.
        i_reset      = 1'b1;
        i_cpu_valid  = 1'b1;
        i_cpu_addr   = 8'h55;
        i_cpu_data   = 24'h123456;
        i_fill_start = 1'b1;
        i_fill_base  = 8'h00;
        i_fill_count = 9'd3;
        i_fill_color = 24'hFFFFFF;
        tick(3);
        check("ready_in_reset", {31'd0, o_cpu_ready}, 32'd0);
        i_reset      = 1'b0;
        i_cpu_valid  = 1'b0;
        i_fill_start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_wen", {31'd0, o_rd_wen}, 32'd0);
        check("rst_addr", {24'd0, o_rd_addr}, 32'd0);
        check("rst_data", {8'd0, o_rd_data}, 32'd0);
        check("rst_busy", {31'd0, o_fill_busy}, 32'd0);
        check("rst_done", {31'd0, o_fill_done}, 32'd0);
        @(negedge clk);

        // Table-driven back-to-back CPU writes in IDLE.
        for (int i = 0; i < 5; i++) begin
            i_cpu_valid = 1'b1;
            i_cpu_addr  = vecs[i].addr;
            i_cpu_data  = vecs[i].data;
            #1;
            check("cpu_ready_idle", {31'd0, o_cpu_ready}, 32'd1);
            push(vecs[i].exp_addr, vecs[i].exp_data, 1'b0, cyc + 1);
            @(negedge clk);
        end
        i_cpu_valid = 1'b0;
        tick(2);
        check("cpu_drained", sb.size(), 0);

        // Fill wrapping past the top of the strip.
        done_cnt = 0;
        c = cyc;
        for (int k = 0; k < 4; k++) push(8'(254 + k), 24'h102030, k == 3, c + 2 + k);
        start_fill(8'hFE, 9'd4, 24'h102030);
        check("wrap_busy", {31'd0, o_fill_busy}, 32'd1);
        tick(4);
        check("wrap_busy_end", {31'd0, o_fill_busy}, 32'd0);
        check("wrap_done_cnt", done_cnt, 1);
        check("wrap_drained", sb.size(), 0);

        // Fill interleaved with a CPU writer that never lets go.
        done_cnt = 0;
        c = cyc;
        for (int k = 1; k <= 11; k++) begin
            if (k % 2 == 1) push(8'((k - 1) / 2), 24'hABCDEF, k == 11, c + 1 + k);
            else            push(8'h80, 24'h5A5A5A, 1'b0, c + 1 + k);
        end
        start_fill(8'h00, 9'd6, 24'hABCDEF);
        for (int k = 1; k <= 10; k++) begin
            i_cpu_valid = 1'b1;
            i_cpu_addr  = 8'h80;
            i_cpu_data  = 24'h5A5A5A;
            #1;
            check("rr_ready", {31'd0, o_cpu_ready}, {31'd0, (k % 2 == 0)});
            @(negedge clk);
        end
        i_cpu_valid = 1'b0;
        tick(2);
        check("rr_done_cnt", done_cnt, 1);
        check("rr_drained", sb.size(), 0);
        check("rr_busy_end", {31'd0, o_fill_busy}, 32'd0);

        // Zero-length fill: done next cycle, no writes, never busy.
        done_cnt     = 0;
        i_fill_start = 1'b1;
        i_fill_base  = 8'h10;
        i_fill_count = 9'd0;
        i_fill_color = 24'h999999;
        @(posedge clk);
        #1;
        check("zero_done", {31'd0, o_fill_done}, 32'd1);
        check("zero_busy", {31'd0, o_fill_busy}, 32'd0);
        @(negedge clk);
        i_fill_start = 1'b0;
        @(posedge clk);
        #1;
        check("zero_done_pulse", {31'd0, o_fill_done}, 32'd0);
        tick(3);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_no_writes", sb.size(), 0);

        // Reset partway through a fill.
        done_cnt = 0;
        c = cyc;
        for (int k = 0; k < 3; k++) push(8'(16 + k), 24'h445566, 1'b0, c + 2 + k);
        start_fill(8'h10, 9'd10, 24'h445566);
        tick(3);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wen", {31'd0, o_rd_wen}, 32'd0);
        check("abort_addr", {24'd0, o_rd_addr}, 32'd0);
        check("abort_data", {8'd0, o_rd_data}, 32'd0);
        check("abort_busy", {31'd0, o_fill_busy}, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        tick(15);
        check("abort_no_done", done_cnt, 0);
        check("abort_drained", sb.size(), 0);

        // Second start during FILL is ignored.
        done_cnt = 0;
        c = cyc;
        for (int k = 0; k < 5; k++) push(8'(5 + k), 24'h111111, k == 4, c + 2 + k);
        start_fill(8'h05, 9'd5, 24'h111111);
        tick(1);
        start_fill(8'h40, 9'd3, 24'h222222);
        tick(8);
        check("restart_done_cnt", done_cnt, 1);
        check("restart_drained", sb.size(), 0);

        // CPU write and fill start in the same IDLE cycle.
        done_cnt = 0;
        c = cyc;
        push(8'h33, 24'h0F0F0F, 1'b0, c + 1);
        push(8'h20, 24'h777777, 1'b0, c + 2);
        push(8'h21, 24'h777777, 1'b1, c + 3);
        i_cpu_valid = 1'b1;
        i_cpu_addr  = 8'h33;
        i_cpu_data  = 24'h0F0F0F;
        start_fill(8'h20, 9'd2, 24'h777777);
        i_cpu_valid = 1'b0;
        tick(4);
        check("same_done_cnt", done_cnt, 1);
        check("same_drained", sb.size(), 0);

        // Full-strip fill touches every address exactly once.
        done_cnt = 0;
        c = cyc;
        for (int k = 0; k < 256; k++) push(8'(55 + k), 24'hC0FFEE, k == 255, c + 2 + k);
        start_fill(8'h37, 9'd256, 24'hC0FFEE);
        tick(258);
        check("full_done_cnt", done_cnt, 1);
        check("full_drained", sb.size(), 0);
        check("full_busy_end", {31'd0, o_fill_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
